// File: rtl/lstm_sequencer_if.sv
// Stream, cell and result handshake bundle between the LSTM sequencer and its neighbours.
interface lstm_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();

  // Input sequence stream
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;

  // Cell x port and recurrent state inputs
  logic [WIDTH-1:0] cell_x;
  logic             cell_x_valid;
  logic             cell_x_ready;
  logic [WIDTH-1:0] cell_h;
  logic [WIDTH-1:0] cell_c;

  // Cell result
  logic [WIDTH-1:0] cell_y;
  logic [WIDTH-1:0] cell_c_out;
  logic             cell_y_valid;

  // Output stream
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  // Sequencer side
  modport master (
    input  s_data, s_valid, s_last, cell_x_ready, cell_y, cell_c_out, cell_y_valid, m_ready,
    output s_ready, cell_x, cell_x_valid, cell_h, cell_c, m_data, m_valid, m_last
  );

  // Environment side (source, cell and sink)
  modport slave (
    output s_data, s_valid, s_last, cell_x_ready, cell_y, cell_c_out, cell_y_valid, m_ready,
    input  s_ready, cell_x, cell_x_valid, cell_h, cell_c, m_data, m_valid, m_last
  );

endinterface

// File: rtl/lstm_sequencer.sv
// Steps an external LSTM cell through an input sequence, carrying h/C between timesteps.
module lstm_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CELL_LAT = 5,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned OUT_ALL  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [WIDTH-1:0]    init_h,
  input  logic [WIDTH-1:0]    init_c,
  lstm_sequencer_if.master    bus,
  output logic [7:0]          step_cnt,
  output logic                err
);

  // Wait counter must span the timeout window and, at minimum, the nominal cell latency.
  localparam int unsigned WAIT_SPAN = (TIMEOUT > CELL_LAT) ? TIMEOUT : CELL_LAT;
  localparam int unsigned WCW       = (WAIT_SPAN < 2) ? 1 : $clog2(WAIT_SPAN + 1);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q;
  logic [WIDTH-1:0] h_reg, c_reg;
  logic [WIDTH-1:0] m_data_q;
  logic             m_valid_q, m_last_q;
  logic             last_q;

  logic s_ready_c;
  logic hs_c;
  logic capture_c;
  logic reinit_c;
  logic timeout_c;
  logic wait_clr_c;
  logic wait_inc_c;

  // Input acceptance is a pure function of state, cell backpressure and flush.
  assign s_ready_c = (state_q == ACCEPT) && bus.cell_x_ready && !flush;
  assign hs_c      = bus.s_valid && s_ready_c;

  assign bus.s_ready      = s_ready_c;
  assign bus.cell_x       = bus.s_data;
  assign bus.cell_x_valid = hs_c;
  assign bus.cell_h       = h_reg;
  assign bus.cell_c       = c_reg;
  assign bus.m_data       = m_data_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_last       = m_last_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCEPT;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    capture_c  = 1'b0;
    reinit_c   = 1'b0;
    timeout_c  = 1'b0;
    wait_clr_c = 1'b0;
    wait_inc_c = 1'b0;
    if (flush) begin
      state_d    = ACCEPT;
      reinit_c   = 1'b1;
      wait_clr_c = 1'b1;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (hs_c) begin
            state_d    = WAIT;
            wait_clr_c = 1'b1;
          end
        end
        WAIT: begin
          if (bus.cell_y_valid) begin
            capture_c  = 1'b1;
            wait_clr_c = 1'b1;
            state_d    = ((OUT_ALL != 0) || last_q) ? HOLD : ACCEPT;
          end else if (wait_q == WCW'(TIMEOUT - 1)) begin
            timeout_c  = 1'b1;
            reinit_c   = 1'b1;
            wait_clr_c = 1'b1;
            state_d    = ACCEPT;
          end else begin
            wait_inc_c = 1'b1;
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            state_d = ACCEPT;
            if (last_q) reinit_c = 1'b1;
          end
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  // Cycles spent waiting on the cell for the current element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          wait_q <= '0;
    else if (wait_clr_c) wait_q <= '0;
    else if (wait_inc_c) wait_q <= wait_q + WCW'(1);
  end

  // Recurrent h/C state and the last-element marker of the element in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg  <= init_h;
      c_reg  <= init_c;
      last_q <= 1'b0;
    end else if (reinit_c) begin
      h_reg  <= init_h;
      c_reg  <= init_c;
      last_q <= 1'b0;
    end else begin
      if (capture_c) begin
        h_reg <= bus.cell_y;
        c_reg <= bus.cell_c_out;
      end
      if (hs_c) last_q <= bus.s_last;
    end
  end

  // Output beat: valid exactly while the FSM sits in HOLD; payload frozen until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      m_valid_q <= (state_d == HOLD);
      if (capture_c) begin
        m_data_q <= bus.cell_y;
        m_last_q <= last_q;
      end else if (state_d != HOLD) begin
        m_last_q <= 1'b0;
      end
    end
  end

  // Timestep index (saturating) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      if (timeout_c) err <= 1'b1;
      if (reinit_c)                               step_cnt <= 8'd0;
      else if (capture_c && (step_cnt != 8'hFF))  step_cnt <= step_cnt + 8'd1;
    end
  end

endmodule

// File: doc/lstm_sequencer.md
LSTM_SEQUENCER -- requirements
Module: lstm_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data, hidden-state and cell-state width, signed two's complement.
REQ-002 SHALL have parameter CELL_LAT, default 5: cycles from cell_x_valid to cell_y_valid.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before error.
REQ-004 SHALL have parameter OUT_ALL, default 1: 1 emits h every timestep; 0 emits only the last timestep.
REQ-005 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have flush  input  1  synchronous abort of the current sequence.
REQ-008 SHALL have init_h, init_c  input  WIDTH each  initial h and C loaded at each sequence start.
REQ-009 SHALL have s_data  input  WIDTH,  s_valid  input  1,  s_last  input  1,  s_ready  output  1  forming the input sequence stream.
REQ-010 SHALL have cell_x  output  WIDTH,  cell_x_valid  output  1,  cell_x_ready  input  1  driving the cell's x port.
REQ-011 SHALL have cell_h, cell_c  output  WIDTH each  driving the cell's h_in and C_in.
REQ-012 SHALL have cell_y, cell_c_out  input  WIDTH each, and cell_y_valid  input  1  carrying the cell result.
REQ-013 SHALL have m_data  output  WIDTH,  m_valid  output  1,  m_last  output  1,  m_ready  input  1  forming the output stream.
REQ-014 SHALL have step_cnt  output  8  timestep index in the current sequence, and err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states ACCEPT, WAIT, HOLD.
REQ-016 SHALL drive s_ready = (state==ACCEPT) & cell_x_ready & !flush, combinationally.
REQ-017 SHALL drive cell_x = s_data and cell_x_valid = s_valid & s_ready, combinationally.
REQ-018 SHALL, on an accepted handshake, register s_last into last_q and go ACCEPT->WAIT.
REQ-019 SHALL drive cell_h/cell_c from h_reg/c_reg; these registers are held constant from handshake until capture.
REQ-020 SHALL, in WAIT with cell_y_valid=1, load h_reg<=cell_y, c_reg<=cell_c_out and m_data<=cell_y, and increment step_cnt (saturating at 255).
REQ-021 SHALL take the WAIT exit on capture to HOLD when OUT_ALL=1 or last_q=1; otherwise the exit goes to ACCEPT.
REQ-022 SHALL assert m_valid only in HOLD, with m_last = last_q; m_data, m_valid and m_last stay stable until m_ready=1.
REQ-023 SHALL, on HOLD with m_ready=1, go to ACCEPT; if last_q=1, it additionally loads h_reg<=init_h, c_reg<=init_c and step_cnt<=0.
REQ-024 SHALL, on a last-element capture with OUT_ALL=0 not reaching HOLD, apply no re-init; re-init occurs only on the HOLD exit of REQ-023.
REQ-025 SHALL count WAIT cycles; if TIMEOUT cycles elapse without cell_y_valid, it sets err=1, goes to ACCEPT, reloads init_h/init_c and clears step_cnt.
REQ-026 SHALL treat flush=1 as highest priority in any state: next state ACCEPT, m_valid=0, init reload, step_cnt=0, no handshake that cycle.
REQ-027 SHALL ignore cell_y_valid outside WAIT, including late results after a flush or timeout; such results set no flags.
REQ-028 SHALL give latency: handshake at cycle T -> capture at edge T+CELL_LAT -> m_valid high from T+CELL_LAT+1.
REQ-029 SHALL sustain a minimum issue interval of CELL_LAT+2 cycles per element with m_ready tied high.

Reset
REQ-030 SHALL, while rst_n=0, force state=ACCEPT, h_reg=init_h, c_reg=init_c, m_data=0, m_valid=0, m_last=0, last_q=0, step_cnt=0, err=0, wait counter=0.
REQ-031 SHALL, when rst_n=0 is applied mid-sequence, discard the in-flight result and resume in ACCEPT after release.
REQ-032 SHALL clear err only by rst_n.

Verification
REQ-033 SHALL cover a 3-element sequence with OUT_ALL=1, init_h=0, init_c=0 and a cell model returning y=0x0010*k -> m_data 0x0010, 0x0020, 0x0030; m_last only on the third; step_cnt 1,2,3 then 0.
REQ-034 SHALL cover OUT_ALL=0 with a 4-element sequence -> exactly one m_valid beat, m_last=1, m_data = fourth cell_y; cell_h on elements 2-4 equals the previous cell_y.
REQ-035 SHALL cover m_ready held low 10 cycles in HOLD -> s_ready=0 throughout; m_data stable; no second cell_x_valid issued.
REQ-036 SHALL cover a cell model that never returns, TIMEOUT=16 -> err=1 exactly 16 cycles after entering WAIT; s_ready returns high; cell_h=init_h.
REQ-037 SHALL cover flush 2 cycles after a handshake followed by a late cell_y_valid -> no m_valid, h_reg unchanged from init, err=0.
REQ-038 SHALL cover rst_n pulsed low during WAIT with init_h=0x0100 -> all outputs at reset values; cell_h=0x0100 after release.
